// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - partial-sum in / accumulated-result out bundle
//
// Purpose: groups the PE partial-sum stream, the result handshake and the
// status outputs of psum_accumulator into one interface.
// Ports (as seen from the accumulator, modport slave):
//   i_psum      in  BIT_WIDTH  partial sum from the PE, two's complement
//   i_psum_val  in  1          i_psum valid this cycle
//   i_acc_rdy   in  1          consumer accepts o_acc this cycle
//   o_acc       out ACC_WIDTH  result FIFO head
//   o_acc_val   out 1          result FIFO non-empty
//   o_cnt       out CNT_W      partial sums taken into the current group
//   o_overflow  out 1          sticky: a finished result was dropped
// The master modport is the mirror view used by the PE/consumer side.
interface psum_accumulator_if #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 20,
  parameter int NUM_ACC   = 9
);
  localparam int CNT_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

  logic [BIT_WIDTH-1:0] i_psum;
  logic                 i_psum_val;
  logic                 i_acc_rdy;
  logic [ACC_WIDTH-1:0] o_acc;
  logic                 o_acc_val;
  logic [CNT_W-1:0]     o_cnt;
  logic                 o_overflow;

  modport slave (
    input  i_psum, i_psum_val, i_acc_rdy,
    output o_acc, o_acc_val, o_cnt, o_overflow
  );

  modport master (
    output i_psum, i_psum_val, i_acc_rdy,
    input  o_acc, o_acc_val, o_cnt, o_overflow
  );
endinterface

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - groups NUM_ACC partial sums into wide results and queues them
//
// Purpose: sign-extends each valid partial sum, accumulates NUM_ACC of them
// into one ACC_WIDTH word, and pushes the finished word into a show-ahead
// FIFO drained through a valid/ready handshake. The PE cannot be stalled, so
// a push into a full FIFO with no simultaneous pop is dropped and latches a
// sticky overflow flag.
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous active-high reset
//   bus  psum_accumulator_if.slave  (stream in, result out, status)
module psum_accumulator #(
  parameter int BIT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int NUM_ACC    = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  psum_accumulator_if.slave       bus
);
  localparam int CNT_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_ACC - 1);
  localparam logic [AW:0]      FIFO_FULLC = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_LAST  = 1'b1
  } state_t;

  // With a single-sum group every valid input is the last of its group.
  localparam state_t ST_START = (NUM_ACC == 1) ? ST_LAST : ST_ACCUM;

  // ---------------------------------------------------------------- group
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_push;

  assign w_ext     = ACC_WIDTH'($signed(bus.i_psum));
  assign w_sum     = r_acc + w_ext;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_START;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_push      = 1'b0;
    if (bus.i_psum_val) begin
      if (r_state == ST_LAST) begin
        // Finished word goes straight to the FIFO; the accumulator restarts
        // even if the FIFO refuses the word.
        w_push      = 1'b1;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_START;
      end else begin
        w_acc_nxt   = w_sum;
        w_cnt_nxt   = w_cnt_inc;
        w_state_nxt = (w_cnt_inc == CNT_LAST) ? ST_LAST : ST_ACCUM;
      end
    end
  end

  // ----------------------------------------------------------------- fifo
  logic [ACC_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_overflow;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FIFO_FULLC);
  assign w_pop   = !w_empty && bus.i_acc_rdy;
  // A pop on the same edge frees the slot the push lands in.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only observable while non-empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_sum;
    end
  end

  assign bus.o_acc      = r_mem[r_rd_ptr];
  assign bus.o_acc_val  = !w_empty;
  assign bus.o_cnt      = r_cnt;
  assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed self-checking bench for psum_accumulator
module tb_psum_accumulator;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  psum_accumulator_if #(.BIT_WIDTH(8), .ACC_WIDTH(20), .NUM_ACC(9)) b0 ();
  psum_accumulator_if #(.BIT_WIDTH(8), .ACC_WIDTH(8),  .NUM_ACC(9)) b1 ();

  psum_accumulator #(.BIT_WIDTH(8), .ACC_WIDTH(20), .NUM_ACC(9), .FIFO_DEPTH(4)) d0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  psum_accumulator #(.BIT_WIDTH(8), .ACC_WIDTH(8), .NUM_ACC(9), .FIFO_DEPTH(4)) d1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Nine back-to-back valid inputs of value d on DUT 0, optionally checking o_cnt.
  task automatic feed_group(input logic [7:0] d, input bit chk_cnt);
    for (int i = 0; i < 9; i++) begin
      b0.i_psum     = d;
      b0.i_psum_val = 1'b1;
      if (chk_cnt) check("cnt_seq", 32'(b0.o_cnt), 32'(i));
      cyc();
    end
    b0.i_psum_val = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b0.i_psum = '0; b0.i_psum_val = 1'b0; b0.i_acc_rdy = 1'b0;
    b1.i_psum = '0; b1.i_psum_val = 1'b0; b1.i_acc_rdy = 1'b0;
    cyc();
    cyc();
    check("rst_val",  32'(b0.o_acc_val),  32'd0);
    check("rst_cnt",  32'(b0.o_cnt),      32'd0);
    check("rst_ovf",  32'(b0.o_overflow), 32'd0);
    rst = 1'b0;
    cyc();

    // Basic group 1..9 -> 45, visible for exactly one cycle.
    b0.i_acc_rdy = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      b0.i_psum     = 8'(i);
      b0.i_psum_val = 1'b1;
      check("basic_cnt", 32'(b0.o_cnt), 32'(i - 1));
      check("basic_noval", 32'(b0.o_acc_val), 32'd0);
      cyc();
    end
    b0.i_psum_val = 1'b0;
    check("basic_val", 32'(b0.o_acc_val), 32'd1);
    check("basic_acc", 32'(b0.o_acc),     32'd45);
    check("basic_cnt0", 32'(b0.o_cnt),    32'd0);
    cyc();
    check("basic_once", 32'(b0.o_acc_val), 32'd0);

    // Signed: nine -128 -> -1152.
    feed_group(8'h80, 1'b0);
    check("neg_val", 32'(b0.o_acc_val), 32'd1);
    check("neg_acc", 32'(b0.o_acc),     32'h000FFB80);
    cyc();
    check("neg_once", 32'(b0.o_acc_val), 32'd0);

    // Gapped valid: nine 2s with idle cycles between, count holds in gaps.
    for (int i = 0; i < 9; i++) begin
      b0.i_psum     = 8'd2;
      b0.i_psum_val = 1'b1;
      cyc();
      b0.i_psum_val = 1'b0;
      b0.i_psum     = 8'd77;
      if (i < 8) begin
        check("gap_cnt_a", 32'(b0.o_cnt), 32'(i + 1));
        cyc();
        check("gap_cnt_hold", 32'(b0.o_cnt), 32'(i + 1));
        check("gap_noval", 32'(b0.o_acc_val), 32'd0);
      end
    end
    check("gap_val", 32'(b0.o_acc_val), 32'd1);
    check("gap_acc", 32'(b0.o_acc),     32'd18);
    cyc();
    check("gap_once", 32'(b0.o_acc_val), 32'd0);

    // Backpressure: five groups of ones with no consumer; fifth is dropped.
    b0.i_acc_rdy = 1'b0;
    for (int g = 0; g < 4; g++) feed_group(8'd1, 1'b0);
    check("bp_ovf_before", 32'(b0.o_overflow), 32'd0);
    feed_group(8'd1, 1'b0);
    check("bp_ovf_after", 32'(b0.o_overflow), 32'd1);
    check("bp_cnt0", 32'(b0.o_cnt), 32'd0);
    b0.i_acc_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_val", 32'(b0.o_acc_val), 32'd1);
      check("bp_drain_acc", 32'(b0.o_acc),     32'd9);
      cyc();
    end
    check("bp_empty", 32'(b0.o_acc_val), 32'd0);
    check("bp_ovf_sticky", 32'(b0.o_overflow), 32'd1);

    // Full with simultaneous pop: reset to clear overflow, fill 9/18/27/36.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("fp_ovf_clr", 32'(b0.o_overflow), 32'd0);
    b0.i_acc_rdy = 1'b0;
    for (int g = 1; g <= 4; g++) feed_group(8'(g), 1'b0);
    for (int i = 0; i < 9; i++) begin
      b0.i_psum     = 8'd5;
      b0.i_psum_val = 1'b1;
      if (i == 8) begin
        check("fp_head_pre", 32'(b0.o_acc), 32'd9);
        b0.i_acc_rdy = 1'b1;
      end
      cyc();
    end
    b0.i_psum_val = 1'b0;
    check("fp_ovf", 32'(b0.o_overflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("fp_drain_val", 32'(b0.o_acc_val), 32'd1);
      check("fp_drain_acc", 32'(b0.o_acc),     32'(18 + 9 * k));
      cyc();
    end
    check("fp_empty", 32'(b0.o_acc_val), 32'd0);

    // Reset mid-group with one result queued.
    b0.i_acc_rdy = 1'b0;
    feed_group(8'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      b0.i_psum     = 8'd5;
      b0.i_psum_val = 1'b1;
      cyc();
    end
    b0.i_psum_val = 1'b0;
    check("mr_cnt_pre", 32'(b0.o_cnt),     32'd4);
    check("mr_val_pre", 32'(b0.o_acc_val), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_val_rst", 32'(b0.o_acc_val),  32'd0);
    check("mr_cnt_rst", 32'(b0.o_cnt),      32'd0);
    check("mr_ovf_rst", 32'(b0.o_overflow), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    b0.i_acc_rdy = 1'b1;
    feed_group(8'd1, 1'b1);
    check("mr_val", 32'(b0.o_acc_val), 32'd1);
    check("mr_acc", 32'(b0.o_acc),     32'd9);
    cyc();
    check("mr_once", 32'(b0.o_acc_val), 32'd0);

    // Narrow accumulator wraps: 9 * 127 mod 256 = 0x77.
    b1.i_acc_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b1.i_psum     = 8'h7F;
      b1.i_psum_val = 1'b1;
      cyc();
    end
    b1.i_psum_val = 1'b0;
    check("wrap_val", 32'(b1.o_acc_val), 32'd1);
    check("wrap_acc", 32'(b1.o_acc),     32'h77);
    cyc();
    check("wrap_once", 32'(b1.o_acc_val), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
